// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default latencies for the
// ALU issue controller.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int DEF_LAT_ADD = 1;
    localparam int DEF_LAT_SUB = 1;
    localparam int DEF_LAT_MUL = 2;
    localparam int DEF_LAT_DIV = 4;

    // Wide enough to hold LAT-1 for the largest legal latency of 8.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to an external combinational ALU, waits the
// per-opcode settle time, then holds the result until writeback takes it.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int LAT_ADD = DEF_LAT_ADD,
    parameter int LAT_SUB = DEF_LAT_SUB,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_DIV = DEF_LAT_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_rs,
    input  logic [7:0] in_rt,
    input  logic [1:0] in_op,
    input  logic [3:0] in_rd,
    output logic [7:0] alu_rs,
    output logic [7:0] alu_rt,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [3:0] out_rd,
    output logic       out_divz,
    output logic       busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rs_q, rs_d, rt_q, rt_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         rd_q, rd_d;
    logic [7:0]         data_q, data_d;
    logic               divz_q, divz_d;

    logic               accept;
    logic               acceptDivz;
    logic [CNT_W-1:0]   latSel;

    assign accept     = in_valid && in_ready;
    assign acceptDivz = (in_op == OP_DIV) && (in_rt == 8'd0);

    always_comb begin
        latSel = CNT_W'(LAT_ADD - 1);
        case (in_op)
            OP_ADD:  latSel = CNT_W'(LAT_ADD - 1);
            OP_SUB:  latSel = CNT_W'(LAT_SUB - 1);
            OP_MUL:  latSel = CNT_W'(LAT_MUL - 1);
            OP_DIV:  latSel = CNT_W'(LAT_DIV - 1);
            default: latSel = CNT_W'(LAT_ADD - 1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Acceptance takes priority: from DONE it retires the old result and
    // starts the new one on the same edge, so there is no idle bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = acceptDivz ? ST_DONE : ST_EXEC;
            cnt_d   = acceptDivz ? '0 : latSel;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        rs_d   = rs_q;
        rt_d   = rt_q;
        op_d   = op_q;
        rd_d   = rd_q;
        data_d = data_q;
        divz_d = divz_q;
        if (accept) begin
            rs_d = in_rs;
            rt_d = in_rt;
            op_d = in_op;
            rd_d = in_rd;
            if (acceptDivz) begin
                data_d = 8'hFF;
                divz_d = 1'b1;
            end
        end else if ((state_q == ST_EXEC) && (cnt_q == '0)) begin
            data_d = alu_out;
            divz_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q   <= '0;
            rt_q   <= '0;
            op_q   <= OP_ADD;
            rd_q   <= '0;
            data_q <= '0;
            divz_q <= 1'b0;
        end else begin
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            op_q   <= op_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            divz_q <= divz_d;
        end
    end

    assign alu_rs   = rs_q;
    assign alu_rt   = rt_q;
    assign alu_op   = op_q;
    assign out_data = data_q;
    assign out_rd   = rd_q;
    assign out_divz = divz_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a vector table of single operations plus
// hand-written back-pressure, back-to-back and reset sequences.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [7:0] inRs, inRt;
    logic [1:0] inOp;
    logic [3:0] inRd;
    logic [7:0] aluRs, aluRt;
    logic [1:0] aluOp;
    logic [7:0] aluOut;
    logic       outValid;
    logic       outReady;
    logic [7:0] outData;
    logic [3:0] outRd;
    logic       outDivz;
    logic       busy;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] rs;
        logic [7:0] rt;
        logic [3:0] rd;
        logic [7:0] expData;
        logic       expDivz;
        int         expLat;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    // Behavioural stand-in for the parent's combinational ALU.
    always_comb begin
        aluOut = 8'h00;
        case (aluOp)
            2'b00: aluOut = aluRs + aluRt;
            2'b01: aluOut = aluRs - aluRt;
            2'b10: aluOut = 8'((16'(aluRs) * 16'(aluRt)) & 16'h00FF);
            2'b11: aluOut = (aluRt == 8'd0) ? 8'hFF : aluRs / aluRt;
            default: aluOut = 8'h00;
        endcase
    end

    alu_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_rs     (inRs),
        .in_rt     (inRt),
        .in_op     (inOp),
        .in_rd     (inRd),
        .alu_rs    (aluRs),
        .alu_rt    (aluRt),
        .alu_op    (aluOp),
        .alu_out   (aluOut),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_rd    (outRd),
        .out_divz  (outDivz),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [7:0] rs,
                                 input logic [7:0] rt, input logic [3:0] rd);
        inValid = v;
        inOp    = op;
        inRs    = rs;
        inRt    = rt;
        inRd    = rd;
    endtask

    // Counts edges after the accepting edge until out_valid is seen, bounded.
    task automatic waitValid(output int edges);
        edges = 0;
        while (!outValid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int edges;
        @(negedge clk);
        checkOutput($sformatf("v%0d in_ready idle", idx), 32'(inReady), 32'd1);
        applyStimulus(1'b1, v.op, v.rs, v.rt, v.rd);
        outReady = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 4'h0);
        waitValid(edges);
        checkOutput($sformatf("v%0d latency", idx), 32'(edges), 32'(v.expLat));
        checkOutput($sformatf("v%0d out_data", idx), 32'(outData), 32'(v.expData));
        checkOutput($sformatf("v%0d out_rd", idx), 32'(outRd), 32'(v.rd));
        checkOutput($sformatf("v%0d out_divz", idx), 32'(outDivz), 32'(v.expDivz));
        checkOutput($sformatf("v%0d alu operands", idx), {14'd0, aluOp, aluRs, aluRt},
                    {14'd0, v.op, v.rs, v.rt});
        checkOutput($sformatf("v%0d in_ready done", idx), 32'(inReady), 32'd0);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput($sformatf("v%0d retire", idx), {30'd0, outValid, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;
        vecs[0] = '{2'b00, 8'h12, 8'h34, 4'h3, 8'h46, 1'b0, 1};
        vecs[1] = '{2'b01, 8'd5,  8'd7,  4'h5, 8'hFE, 1'b0, 1};
        vecs[2] = '{2'b10, 8'd20, 8'd20, 4'h6, 8'h90, 1'b0, 2};
        vecs[3] = '{2'b11, 8'd100, 8'd7, 4'h9, 8'd14, 1'b0, 4};
        vecs[4] = '{2'b11, 8'd9,  8'd0,  4'hA, 8'hFF, 1'b1, 0};
        vecs[5] = '{2'b00, 8'hFF, 8'h01, 4'hF, 8'h00, 1'b0, 1};
        vecs[6] = '{2'b10, 8'd16, 8'd16, 4'h1, 8'h00, 1'b0, 2};
        vecs[7] = '{2'b11, 8'd255, 8'd1, 4'h2, 8'hFF, 1'b0, 4};
        vecs[8] = '{2'b01, 8'd0,  8'd1,  4'h7, 8'hFF, 1'b0, 1};
        vecs[9] = '{2'b11, 8'd0,  8'd0,  4'h4, 8'hFF, 1'b1, 0};

        reset    = 1'b1;
        outReady = 1'b0;
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 4'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {14'd0, aluOp, aluRs, aluRt}, 32'd0);
        checkOutput("reset status", {18'd0, outValid, outData, outRd, outDivz, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after reset", 32'(inReady), 32'd1);

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], i);
        end

        // Back-pressure: MUL result held while writeback stalls; a waiting
        // request must not be taken.
        @(negedge clk);
        applyStimulus(1'b1, 2'b10, 8'd20, 8'd20, 4'hC);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 8'h01, 8'h01, 4'h2);
        waitValid(edges);
        checkOutput("stall latency", 32'(edges), 32'd2);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall c%0d data", c), {23'd0, outValid, outData}, {23'd0, 1'b1, 8'h90});
            checkOutput($sformatf("stall c%0d in_ready", c), 32'(inReady), 32'd0);
            checkOutput($sformatf("stall c%0d rd", c), 32'(outRd), 32'hC);
            @(negedge clk);
        end

        // Back-to-back: release the held MUL while issuing SUB 5-7.
        applyStimulus(1'b1, 2'b01, 8'd5, 8'd7, 4'hB);
        outReady = 1'b1;
        #1;
        checkOutput("b2b in_ready", 32'(inReady), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 4'h0);
        outReady = 1'b0;
        checkOutput("b2b no idle", {30'd0, busy, outValid}, {30'd0, 1'b1, 1'b0});
        waitValid(edges);
        checkOutput("b2b latency", 32'(edges), 32'd1);
        checkOutput("b2b data", {24'd0, outRd, outDivz, 3'd0} | 32'(outData) << 8,
                    {24'd0, 4'hB, 1'b0, 3'd0} | 32'(8'hFE) << 8);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;

        // in_valid held during EXEC must be ignored.
        applyStimulus(1'b1, 2'b11, 8'd100, 8'd7, 4'h8);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 8'h05, 8'h05, 4'h1);
        checkOutput("exec in_ready", 32'(inReady), 32'd0);
        waitValid(edges);
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 4'h0);
        checkOutput("exec ignore latency", 32'(edges), 32'd4);
        checkOutput("exec ignore data", {20'd0, outRd, outData}, {20'd0, 4'h8, 8'd14});
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;

        // Reset in the middle of a DIV discards it.
        applyStimulus(1'b1, 2'b11, 8'd100, 8'd7, 4'h6);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 8'h00, 8'h00, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst alu", {14'd0, aluOp, aluRs, aluRt}, 32'd0);
        checkOutput("midrst status", {18'd0, outValid, outData, outRd, outDivz, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst in_ready", 32'(inReady), 32'd1);
        edges = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (outValid) edges++;
        end
        checkOutput("midrst no result", 32'(edges), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
